// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: merges the pipeline writeback stream with
// a small queue of divider results. The pipeline always wins the port; queued
// divider results drain whenever the pipeline is quiet. Pipeline writes that
// target a register still pending in the queue kill the stale queued entry.
module regfile_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_rd,
  input  logic [31:0]                wb_data,
  input  logic                       div_valid,
  input  logic [4:0]                 div_rd,
  input  logic [31:0]                div_data,
  output logic                       div_ready,
  output logic                       wr_en,
  output logic [4:0]                 wr_addr,
  output logic [31:0]                wr_data,
  output logic [31:0]                pend_mask,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [4:0]       entry_rd   [DEPTH];
  logic [31:0]      entry_data [DEPTH];
  logic [DEPTH-1:0] entry_live;
  logic [DEPTH-1:0] live_next;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  logic wb_qual;
  logic push;
  logic pop;
  logic head_live;
  logic write_head;

  // Handshake and the push/pop decisions for this cycle. A dead head entry
  // (squashed by a younger pipeline write) drains even while the pipeline
  // owns the write port, since it needs no port slot.
  always_comb begin
    div_ready  = rst_n && (q_count != FULL_COUNT);
    wb_qual    = wb_valid && (wb_rd != 5'd0);
    push       = div_valid && div_ready && (div_rd != 5'd0);
    head_live  = entry_live[rd_ptr];
    pop        = (q_count != '0) && (!head_live || !wb_qual);
    write_head = pop && head_live;
  end

  // Next liveness of each entry: squash matches of a pipeline write, retire
  // the popped head, then mark the newly pushed slot live (divider is younger).
  always_comb begin
    live_next = entry_live;
    if (wb_qual) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_rd[i] == wb_rd) live_next[i] = 1'b0;
      end
    end
    if (pop)  live_next[rd_ptr] = 1'b0;
    if (push) live_next[wr_ptr] = 1'b1;
  end

  // One-hot OR of the destinations of every live queued entry.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_live[i]) pend_mask[entry_rd[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  // Queue payload storage; contents are only meaningful while the slot is live.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_rd[wr_ptr]   <= div_rd;
      entry_data[wr_ptr] <= div_data;
    end
  end

  // Queue bookkeeping: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      q_count    <= '0;
      entry_live <= '0;
    end else begin
      entry_live <= live_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Registered write port: pipeline first, then a live queue head; address
  // and data hold their last values when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (wb_qual) begin
      wr_en   <= 1'b1;
      wr_addr <= wb_rd;
      wr_data <= wb_data;
    end else if (write_head) begin
      wr_en   <= 1'b1;
      wr_addr <= entry_rd[rd_ptr];
      wr_data <= entry_data[rd_ptr];
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter with DEPTH=2.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        div_valid;
  logic [4:0]  div_rd;
  logic [31:0] div_data;
  logic        div_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pend_mask;
  logic [1:0]  q_count;

  int checks;
  int failures;

  regfile_write_arbiter #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .div_valid (div_valid),
    .div_rd    (div_rd),
    .div_data  (div_data),
    .div_ready (div_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pend_mask (pend_mask),
    .q_count   (q_count)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [4:0] wrd, input logic [31:0] wdat,
                               input logic dv, input logic [4:0] drd, input logic [31:0] ddat);
    wb_valid  = wv;
    wb_rd     = wrd;
    wb_data   = wdat;
    div_valid = dv;
    div_rd    = drd;
    div_data  = ddat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("rst_wr_en",     32'(wr_en),     32'd0);
    checkOutput("rst_q_count",   32'(q_count),   32'd0);
    checkOutput("rst_div_ready", 32'(div_ready), 32'd0);
    checkOutput("rst_pend_mask", pend_mask,      32'd0);
    #20 rst_n = 1'b1;
    tick();
    checkOutput("post_rst_wr_en", 32'(wr_en), 32'd0);

    // Single pipeline writeback
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0);
    tick();
    checkOutput("wb_wr_en",   32'(wr_en),   32'd1);
    checkOutput("wb_wr_addr", 32'(wr_addr), 32'd5);
    checkOutput("wb_wr_data", wr_data,      32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("wb_idle_wr_en",   32'(wr_en),   32'd0);
    checkOutput("wb_hold_wr_addr", 32'(wr_addr), 32'd5);
    checkOutput("wb_hold_wr_data", wr_data,      32'hDEADBEEF);

    // Divider result on an idle port
    applyStimulus(0, 0, 0, 1, 7, 32'h12345678);
    #1 checkOutput("div_ready_empty", 32'(div_ready), 32'd1);
    tick();
    checkOutput("div_pend",    pend_mask,     32'h80);
    checkOutput("div_q1",      32'(q_count),  32'd1);
    checkOutput("div_no_wr",   32'(wr_en),    32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("div_wr_en",   32'(wr_en),    32'd1);
    checkOutput("div_wr_addr", 32'(wr_addr),  32'd7);
    checkOutput("div_wr_data", wr_data,       32'h12345678);
    checkOutput("div_pend_clr", pend_mask,    32'd0);
    checkOutput("div_q0",      32'(q_count),  32'd0);

    // Collision with a busy pipeline until the queue is full
    applyStimulus(1, 10, 32'h1, 1, 3, 32'h33);
    tick();
    checkOutput("col_wr_addr_10", 32'(wr_addr), 32'd10);
    checkOutput("col_q1",         32'(q_count), 32'd1);
    applyStimulus(1, 11, 32'h2, 1, 4, 32'h44);
    tick();
    checkOutput("col_q2",        32'(q_count),   32'd2);
    checkOutput("col_ready0",    32'(div_ready), 32'd0);
    checkOutput("col_pend",      pend_mask,      32'h18);
    applyStimulus(1, 12, 32'h3, 1, 5, 32'h55);
    tick();
    checkOutput("col_full_hold", 32'(q_count),   32'd2);
    checkOutput("col_wr_addr_12", 32'(wr_addr),  32'd12);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("col_pop1_addr", 32'(wr_addr),   32'd3);
    checkOutput("col_pop1_data", wr_data,        32'h33);
    checkOutput("col_ready1",    32'(div_ready), 32'd1);
    tick();
    checkOutput("col_pop2_en",   32'(wr_en),     32'd1);
    checkOutput("col_pop2_addr", 32'(wr_addr),   32'd4);
    checkOutput("col_pop2_data", wr_data,        32'h44);
    tick();
    checkOutput("col_drained_en", 32'(wr_en),    32'd0);
    checkOutput("col_drained_q",  32'(q_count),  32'd0);

    // Write-after-write squash of a queued entry
    applyStimulus(0, 0, 0, 1, 9, 32'h99);
    tick();
    checkOutput("waw_pend", pend_mask, 32'h200);
    applyStimulus(1, 9, 32'hAA, 0, 0, 0);
    tick();
    checkOutput("waw_wr_addr",  32'(wr_addr), 32'd9);
    checkOutput("waw_wr_data",  wr_data,      32'hAA);
    checkOutput("waw_pend_clr", pend_mask,    32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("waw_no_wr",    32'(wr_en),   32'd0);
    checkOutput("waw_q0",       32'(q_count), 32'd0);
    tick();
    checkOutput("waw_still_no_wr", 32'(wr_en), 32'd0);

    // Same-cycle push whose rd matches the pipeline write survives
    applyStimulus(1, 6, 32'h61, 1, 6, 32'h66);
    tick();
    checkOutput("same_wb_data", wr_data,   32'h61);
    checkOutput("same_pend",    pend_mask, 32'h40);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("same_div_addr", 32'(wr_addr), 32'd6);
    checkOutput("same_div_data", wr_data,      32'h66);

    // x0 filtering
    applyStimulus(1, 0, 32'h5, 1, 0, 32'h6);
    tick();
    checkOutput("x0_wr_en", 32'(wr_en),   32'd0);
    checkOutput("x0_q",     32'(q_count), 32'd0);
    checkOutput("x0_pend",  pend_mask,    32'd0);

    // Push and pop on the same edge
    applyStimulus(0, 0, 0, 1, 2, 32'h22);
    tick();
    applyStimulus(0, 0, 0, 1, 3, 32'h23);
    tick();
    checkOutput("pp_wr_addr", 32'(wr_addr), 32'd2);
    checkOutput("pp_q",       32'(q_count), 32'd1);
    checkOutput("pp_pend",    pend_mask,    32'h8);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("pp_wr_addr2", 32'(wr_addr), 32'd3);
    checkOutput("pp_wr_data2", wr_data,      32'h23);

    // Reset in the middle of operation with a full queue
    applyStimulus(1, 1, 32'h1, 1, 13, 32'hD);
    tick();
    applyStimulus(1, 1, 32'h1, 1, 14, 32'hE);
    tick();
    checkOutput("mid_q2", 32'(q_count), 32'd2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_wr_en",     32'(wr_en),     32'd0);
    checkOutput("mid_rst_wr_addr",   32'(wr_addr),   32'd0);
    checkOutput("mid_rst_wr_data",   wr_data,        32'd0);
    checkOutput("mid_rst_q",         32'(q_count),   32'd0);
    checkOutput("mid_rst_pend",      pend_mask,      32'd0);
    checkOutput("mid_rst_div_ready", 32'(div_ready), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    checkOutput("mid_after_wr_en", 32'(wr_en),   32'd0);
    checkOutput("mid_after_q",     32'(q_count), 32'd0);
    tick();
    checkOutput("mid_after2_wr_en", 32'(wr_en),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
